// File: rtl/branch_sequencer.sv
// ---------------------------------------------------------------------------
// branch_sequencer
//
// Control sequencer for the conditional-branch path of the CPU. Steps through
// T3..T6 of a branch instruction, driving the register-file / bus control
// strobes for each step. The branch condition is evaluated against the bus
// value during T3 and captured in the CON flag (con_q), which then gates
// the PC write in T6. A start/busy/done handshake talks to the main control
// unit, and two saturating counters keep branch statistics.
//
// Optional feature (compile-time macro BRANCH_SKIP_EN):
//   defined   - a not-taken branch jumps straight from T3 to DONE.
//   undefined - every branch walks T4..T6; a not-taken branch only suppresses
//               z_low_out and pc_in in T6.
//
// Parameters:
//   DATA_WIDTH   width of bus_mux_out
//   COUNT_WIDTH  width of branch_count / taken_count
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   start         run request from main control, honoured only in IDLE
//   ir_cond       IR condition field C2[1:0]
//   bus_mux_out   bus value (Ra contents during T3)
//   busy          high in every state except IDLE
//   done          one-cycle pulse in DONE
//   gra, r_out, con_in               T3 strobes
//   pc_out, y_in                     T4 strobes
//   c_sign_out, alu_add, z_in        T5 strobes
//   z_low_out, pc_in                 T6 strobes, gated by con_q
//   con_q         latched CON flag
//   branch_count  branches evaluated (saturating)
//   taken_count   branches taken (saturating)
// ---------------------------------------------------------------------------
module branch_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             ir_cond,
    input  logic [DATA_WIDTH-1:0]  bus_mux_out,
    output logic                   busy,
    output logic                   done,
    output logic                   gra,
    output logic                   r_out,
    output logic                   con_in,
    output logic                   pc_out,
    output logic                   y_in,
    output logic                   c_sign_out,
    output logic                   alu_add,
    output logic                   z_in,
    output logic                   z_low_out,
    output logic                   pc_in,
    output logic                   con_q,
    output logic [COUNT_WIDTH-1:0] branch_count,
    output logic [COUNT_WIDTH-1:0] taken_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic   cond_eval;
    logic   con_reg;
    logic   t3_exit;
    logic   inc_en [2];

    // ------------------------------------------------------------------
    // Branch condition, evaluated combinationally from the bus value.
    // Only meaningful in T3; the result is captured on the T3 exit edge.
    // ------------------------------------------------------------------
    always_comb begin
        cond_eval = 1'b0;
        case (ir_cond)
            2'b00:   cond_eval = (bus_mux_out == '0);
            2'b01:   cond_eval = (bus_mux_out != '0);
            2'b10:   cond_eval = ~bus_mux_out[DATA_WIDTH-1];
            default: cond_eval =  bus_mux_out[DATA_WIDTH-1];
        endcase
    end

    // Every cycle spent in T3 ends with a transition out of it.
    assign t3_exit = (state_reg == S_T3);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_T3;
                end
            end
            S_T3: begin
`ifdef BRANCH_SKIP_EN
                // Not-taken branches have nothing useful to do in T4..T6.
                state_next = cond_eval ? S_T4 : S_DONE;
`else
                state_next = S_T4;
`endif
            end
            S_T4:    state_next = S_T5;
            S_T5:    state_next = S_T6;
            S_T6:    state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode. Because state_reg clears asynchronously, every
    // strobe drops the moment reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        gra        = 1'b0;
        r_out      = 1'b0;
        con_in     = 1'b0;
        pc_out     = 1'b0;
        y_in       = 1'b0;
        c_sign_out = 1'b0;
        alu_add    = 1'b0;
        z_in       = 1'b0;
        z_low_out  = 1'b0;
        pc_in      = 1'b0;
        case (state_reg)
            S_IDLE: begin
            end
            S_T3: begin
                busy   = 1'b1;
                gra    = 1'b1;
                r_out  = 1'b1;
                con_in = 1'b1;
            end
            S_T4: begin
                busy   = 1'b1;
                pc_out = 1'b1;
                y_in   = 1'b1;
            end
            S_T5: begin
                busy       = 1'b1;
                c_sign_out = 1'b1;
                alu_add    = 1'b1;
                z_in       = 1'b1;
            end
            S_T6: begin
                // The PC is only rewritten when the branch is taken.
                busy      = 1'b1;
                z_low_out = con_reg;
                pc_in     = con_reg;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // CON flag: loaded only when leaving T3, held between branches.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            con_reg <= 1'b0;
        end else if (t3_exit) begin
            con_reg <= cond_eval;
        end
    end

    assign con_q = con_reg;

    // ------------------------------------------------------------------
    // Statistics counters. Index 0 counts every evaluated branch, index 1
    // counts the taken ones. Both stick at all-ones instead of wrapping.
    // ------------------------------------------------------------------
    assign inc_en[0] = t3_exit;
    assign inc_en[1] = t3_exit & cond_eval;

    for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
        logic [COUNT_WIDTH-1:0] cnt_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_reg <= '0;
            end else if (inc_en[gi] && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + COUNT_WIDTH'(1);
            end
        end
    end

    assign branch_count = gen_cnt[0].cnt_reg;
    assign taken_count  = gen_cnt[1].cnt_reg;

endmodule

// File: tb/tb_branch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_branch_sequencer
//
// Self-checking bench for branch_sequencer. A narrow counter width is used so
// saturation is reachable in a short run. Expected strobe patterns per step,
// branch outcome and counter values come from a behavioural model of the
// branch rules (signed arithmetic on the bus value, min() saturation).
// ---------------------------------------------------------------------------
module tb_branch_sequencer;

    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

`ifdef BRANCH_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    // Step identifiers used by the model (0 = idle, 1..4 = T3..T6, 5 = done)
    localparam int PH_IDLE = 0;
    localparam int PH_T3   = 1;
    localparam int PH_T4   = 2;
    localparam int PH_T5   = 3;
    localparam int PH_T6   = 4;
    localparam int PH_DONE = 5;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    ir_cond;
    logic [DW-1:0] bus_mux_out;
    logic          busy, done, gra, r_out, con_in, pc_out, y_in;
    logic          c_sign_out, alu_add, z_in, z_low_out, pc_in, con_q;
    logic [CW-1:0] branch_count, taken_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int txn          = 0;

    // Reference model state
    int m_branch = 0;
    int m_taken  = 0;
    bit m_con    = 1'b0;

    branch_sequencer #(
        .DATA_WIDTH (DW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ir_cond     (ir_cond),
        .bus_mux_out (bus_mux_out),
        .busy        (busy),
        .done        (done),
        .gra         (gra),
        .r_out       (r_out),
        .con_in      (con_in),
        .pc_out      (pc_out),
        .y_in        (y_in),
        .c_sign_out  (c_sign_out),
        .alu_add     (alu_add),
        .z_in        (z_in),
        .z_low_out   (z_low_out),
        .pc_in       (pc_in),
        .con_q       (con_q),
        .branch_count(branch_count),
        .taken_count (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Branch rule: compare the bus value as a signed number.
    function automatic bit ref_cond(input logic [1:0] c, input logic [31:0] v);
        case (c)
            2'd0:    return (v == 32'd0);
            2'd1:    return (v != 32'd0);
            2'd2:    return ($signed(v) >= 0);
            default: return ($signed(v) < 0);
        endcase
    endfunction

    // Observed outputs packed as
    // {busy,done,gra,r_out,con_in,pc_out,y_in,c_sign_out,alu_add,z_in,z_low_out,pc_in}
    function automatic logic [31:0] outs();
        return {20'd0, busy, done, gra, r_out, con_in, pc_out, y_in,
                c_sign_out, alu_add, z_in, z_low_out, pc_in};
    endfunction

    function automatic logic [31:0] exp_outs(input int ph, input bit taken);
        case (ph)
            PH_T3:   return 32'hB80;
            PH_T4:   return 32'h860;
            PH_T5:   return 32'h81C;
            PH_T6:   return taken ? 32'h803 : 32'h800;
            PH_DONE: return 32'hC00;
            default: return 32'h000;
        endcase
    endfunction

    function automatic int sat_inc(input int x);
        return (x < CMAX) ? x + 1 : x;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_con_q"},        {31'd0, con_q},       {31'd0, m_con});
        check({tag, "_branch_count"}, {28'd0, branch_count}, m_branch);
        check({tag, "_taken_count"},  {28'd0, taken_count},  m_taken);
    endtask

    // Runs one branch and checks every cycle from T3 to the IDLE that follows.
    // Called at a negedge. already=1 means the sequence has already entered
    // T3 (start was held), so only the operands are applied here.
    // hold keeps start high throughout; pulse_t4 raises start during T4 only.
    task automatic run_branch(input logic [1:0] c, input logic [31:0] v,
                              input bit hold, input bit pulse_t4, input bit already);
        bit taken;
        int phases[$];
        taken = ref_cond(c, v);
        ir_cond     = c;
        bus_mux_out = v;
        if (!already) begin
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        if (taken || !SKIP) phases = '{PH_T3, PH_T4, PH_T5, PH_T6, PH_DONE, PH_IDLE};
        else                phases = '{PH_T3, PH_DONE, PH_IDLE};
        for (int i = 0; i < phases.size(); i++) begin
            if (i > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            check($sformatf("txn%0d_step%0d_outs", txn, i), outs(), exp_outs(phases[i], taken));
            if (i == 1) begin
                m_con    = taken;
                m_branch = sat_inc(m_branch);
                if (taken) m_taken = sat_inc(m_taken);
                check_regs($sformatf("txn%0d", txn));
            end
            if (i >= 1) begin
                // Operands are don't-care outside T3.
                ir_cond     = 2'($urandom);
                bus_mux_out = $urandom;
            end
            start = hold | (pulse_t4 && (phases[i] == PH_T4));
        end
        $display("[TB] txn %0d cond=%0d val=%08h taken=%0d cycles=%0d branches=%0d taken_cnt=%0d",
                 txn, c, v, taken, phases.size() - 1, branch_count, taken_count);
        txn++;
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        ir_cond     = 2'd0;
        bus_mux_out = '0;

        // Reset held: outputs idle even with start requested.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_low_outs", outs(), 32'h0);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_rel_outs", outs(), 32'h0);
        check_regs("reset_rel");

        // Directed cases
        run_branch(2'b00, 32'h0000_0000, 1'b0, 1'b0, 1'b0); // brzr taken
        run_branch(2'b11, 32'h0000_0005, 1'b0, 1'b0, 1'b0); // brmi not taken
        run_branch(2'b10, 32'h8000_0000, 1'b0, 1'b0, 1'b0); // brpl sign boundary, not taken
        run_branch(2'b10, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0); // brpl sign boundary, taken
        run_branch(2'b01, 32'h0000_0000, 1'b0, 1'b0, 1'b0); // brnz not taken
        run_branch(2'b11, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0); // brmi taken

        // start held high: one sequence per IDLE visit, restart right after IDLE.
        run_branch(2'b01, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        run_branch(2'b00, 32'h0000_0003, 1'b0, 1'b0, 1'b1);

        // Extra start pulse during T4 is ignored.
        run_branch(2'b01, 32'h0000_0009, 1'b0, 1'b1, 1'b0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("after_t4_pulse_idle", outs(), 32'h0);
        end

        // Randomized branches, with boundary values mixed in.
        for (int k = 0; k < 24; k++) begin
            logic [31:0] v;
            case ($urandom_range(0, 3))
                0:       v = 32'h0;
                1:       v = 32'h8000_0000;
                2:       v = 32'h7FFF_FFFF;
                default: v = $urandom;
            endcase
            run_branch(2'($urandom), v, 1'b0, 1'b0, 1'b0);
        end

        // Drive taken_count into saturation as well.
        for (int k = 0; k < CMAX + 2; k++) begin
            run_branch(2'b01, 32'h0000_0001 | $urandom, 1'b0, 1'b0, 1'b0);
        end
        check("sat_branch_all_ones", {28'd0, branch_count}, CMAX);
        check("sat_taken_all_ones",  {28'd0, taken_count},  CMAX);

        // Reset asserted during T5 of a taken branch.
        ir_cond     = 2'b00;
        bus_mux_out = 32'h0;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_con_before", {31'd0, con_q}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("midrst_t5_outs", outs(), 32'h81C);
        reset = 1'b0;
        #1;
        m_con    = 1'b0;
        m_branch = 0;
        m_taken  = 0;
        check("midrst_outs_async", outs(), 32'h0);
        check_regs("midrst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_after_release", outs(), 32'h0);
        check_regs("midrst_after");

        // Sequencer is usable again after the mid-sequence reset.
        run_branch(2'b10, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
